// File: rtl/aes_sbox_stream_cipher_mlane.sv
// -----------------------------------------------------------------------------
// aes_sbox_stream_cipher_mlane
//
// Multi-lane AES S-box keystream cipher. Every accepted beat carries LANES
// bytes. Lane i is XORed with ks = SBOX[K[n mod KEY_BYTES] ^ n], where
// n = C + i (mod 256) and C is the per-message byte counter. Encryption and
// decryption are the same operation.
//
// Two-stage pipeline with valid/ready on both sides:
//   S1 captures input bytes, keep, last and the keystream computed at acceptance.
//   S2 captures the masked XOR result and drives the outputs.
//
// Parameters:
//   LANES      bytes per beat (1..16)
//   KEY_BYTES  key length in bytes (power of two, 1..16)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   key_load            latch simmetric_key, clear byte counter, block input
//   simmetric_key       key bytes, byte k at [8k+7:8k]
//   din_valid/ready     input handshake
//   txt_in_data         input bytes, lane i at [8i+7:8i]
//   din_keep, din_last  lane enables (contiguous from lane 0), end of message
//   dout_valid/ready    output handshake
//   txt_out_data        result bytes, disabled lanes are 8'h00
//   dout_keep, dout_last copies of din_keep / din_last
//   byte_count          (only with AES_SBOX_SC_BYTE_COUNT_EN) saturating count
//                       of output bytes transferred; cleared by reset/key_load
//
// Optional feature macro: AES_SBOX_SC_BYTE_COUNT_EN
// -----------------------------------------------------------------------------
module aes_sbox_stream_cipher_mlane #(
    parameter int LANES     = 4,
    parameter int KEY_BYTES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   key_load,
    input  logic [8*KEY_BYTES-1:0] simmetric_key,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [8*LANES-1:0]     txt_in_data,
    input  logic [LANES-1:0]       din_keep,
    input  logic                   din_last,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [8*LANES-1:0]     txt_out_data,
    output logic [LANES-1:0]       dout_keep,
    output logic                   dout_last
`ifdef AES_SBOX_SC_BYTE_COUNT_EN
    ,
    output logic [31:0]            byte_count
`endif
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Keystream byte for absolute byte index n. KEY_BYTES is a power of two,
    // so the modulo reduces to the low index bits.
    function automatic logic [7:0] ks_byte(input logic [7:0] n,
                                           input logic [8*KEY_BYTES-1:0] key);
        logic [7:0] kb;
        kb = key[8*(int'(n) % KEY_BYTES) +: 8];
        return SBOX[kb ^ n];
    endfunction

    function automatic logic [7:0] popcnt(input logic [LANES-1:0] k);
        logic [7:0] c;
        c = '0;
        for (int i = 0; i < LANES; i++) c = c + 8'(k[i]);
        return c;
    endfunction

    logic [8*KEY_BYTES-1:0] r_key;
    logic [7:0]             r_cnt;

    logic                   r_vld_p1;
    logic [8*LANES-1:0]     r_data_p1;
    logic [8*LANES-1:0]     r_ks_p1;
    logic [LANES-1:0]       r_keep_p1;
    logic                   r_last_p1;

    logic                   r_vld_p2;
    logic [8*LANES-1:0]     r_data_p2;
    logic [LANES-1:0]       r_keep_p2;
    logic                   r_last_p2;

    logic                   w_s2_en;
    logic                   w_s1_en;
    logic                   w_acc;
    logic [8*LANES-1:0]     w_ks;
    logic [8*LANES-1:0]     w_xor_p1;

    // A stage may load when it is empty or its content leaves this cycle.
    assign w_s2_en   = !r_vld_p2 || dout_ready;
    assign w_s1_en   = !r_vld_p1 || w_s2_en;
    assign din_ready = rst_n && !key_load && w_s1_en;
    assign w_acc     = din_valid && din_ready;

    always_comb begin
        w_ks = '0;
        for (int i = 0; i < LANES; i++)
            w_ks[8*i +: 8] = ks_byte(r_cnt + 8'(i), r_key);
    end

    always_comb begin
        w_xor_p1 = '0;
        for (int i = 0; i < LANES; i++)
            if (r_keep_p1[i])
                w_xor_p1[8*i +: 8] = r_data_p1[8*i +: 8] ^ r_ks_p1[8*i +: 8];
    end

    // Key register and per-message byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key <= '0;
            r_cnt <= '0;
        end else if (key_load) begin
            r_key <= simmetric_key;
            r_cnt <= '0;
        end else if (w_acc) begin
            r_cnt <= din_last ? 8'd0 : r_cnt + popcnt(din_keep);
        end
    end

    // ---- Stage p1: captured input beat and its keystream ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p1 <= 1'b0;
        end else if (w_s1_en) begin
            r_vld_p1 <= w_acc;
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_data_p1 <= txt_in_data;
            r_ks_p1   <= w_ks;
            r_keep_p1 <= din_keep;
            r_last_p1 <= din_last;
        end
    end

    // ---- Stage p2: XOR result driving the outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_keep_p2 <= '0;
            r_last_p2 <= 1'b0;
        end else if (w_s2_en) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_xor_p1;
                r_keep_p2 <= r_keep_p1;
                r_last_p2 <= r_last_p1;
            end
        end
    end

    assign dout_valid   = r_vld_p2;
    assign txt_out_data = r_data_p2;
    assign dout_keep    = r_keep_p2;
    assign dout_last    = r_last_p2;

`ifdef AES_SBOX_SC_BYTE_COUNT_EN
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [7:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {25'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    logic [31:0] r_byte_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte_count <= '0;
        end else if (key_load) begin
            r_byte_count <= '0;
        end else if (r_vld_p2 && dout_ready) begin
            r_byte_count <= sat_add32(r_byte_count, popcnt(r_keep_p2));
        end
    end

    assign byte_count = r_byte_count;
`endif

endmodule

// File: tb/tb_aes_sbox_stream_cipher_mlane.sv
module tb_aes_sbox_stream_cipher_mlane;

    logic        clk;
    logic        rst_n;
    logic        key_load;
    logic [31:0] simmetric_key;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] txt_in_data;
    logic [3:0]  din_keep;
    logic        din_last;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] txt_out_data;
    logic [3:0]  dout_keep;
    logic        dout_last;

    int checks   = 0;
    int failures = 0;

    aes_sbox_stream_cipher_mlane #(.LANES(4), .KEY_BYTES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_load     (key_load),
        .simmetric_key(simmetric_key),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .txt_in_data  (txt_in_data),
        .din_keep     (din_keep),
        .din_last     (din_last),
        .dout_valid   (dout_valid),
        .dout_ready   (dout_ready),
        .txt_out_data (txt_out_data),
        .dout_keep    (dout_keep),
        .dout_last    (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference S-box derived from GF(2^8) inversion plus the AES affine map.
    logic [7:0]  sbox_t [256];
    logic [31:0] m_key;

    logic [31:0] q_data[$];
    logic [3:0]  q_keep[$];
    logic        q_last[$];
    logic [31:0] g_data[$];
    logic [3:0]  g_keep[$];
    logic        g_last[$];
    logic [31:0] e_data[$];
    int          hold_err, ready_err, run_cycles;
    bit          run_timeout;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int k);
        logic [7:0] r;
        r = x;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int v = 0; v < 256; v++) begin
            b = 8'(v);
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
            sbox_t[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] model_beat(input logic [31:0] d, input logic [3:0] k,
                                               input logic [7:0] c, input logic [31:0] key);
        logic [31:0] r;
        logic [7:0]  n;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            n = c + 8'(i);
            if (k[i]) r[8*i +: 8] = d[8*i +: 8] ^ sbox_t[key[8*n[1:0] +: 8] ^ n];
        end
        return r;
    endfunction

    task automatic build_expected();
        logic [7:0] c;
        c = 8'h00;
        e_data.delete();
        foreach (q_data[i]) begin
            e_data.push_back(model_beat(q_data[i], q_keep[i], c, m_key));
            c = q_last[i] ? 8'h00 : c + 8'($countones(q_keep[i]));
        end
    endtask

    task automatic clear_queues();
        q_data.delete(); q_keep.delete(); q_last.delete();
    endtask

    task automatic load_key(input logic [31:0] k);
        key_load = 1'b1; simmetric_key = k; din_valid = 1'b0;
        m_key = k;
        @(posedge clk); #1;
        key_load = 1'b0;
    endtask

    // Streams q_* through the DUT, collecting transfers into g_*; records
    // hold violations and din_ready deviations from the two-stage occupancy.
    task automatic send_beats(input bit rnd_ready, input int limit);
        int idx, occ;
        bit acc, xfer, prev_stall;
        logic [31:0] pd; logic [3:0] pk; logic pl; logic exp_rdy;
        idx = 0; occ = 0; prev_stall = 0; pd = '0; pk = '0; pl = 0;
        hold_err = 0; ready_err = 0; run_timeout = 1; run_cycles = 0;
        g_data.delete(); g_keep.delete(); g_last.delete();
        for (int cyc = 0; cyc < limit; cyc++) begin
            if (idx < q_data.size()) begin
                din_valid = 1'b1; txt_in_data = q_data[idx];
                din_keep = q_keep[idx]; din_last = q_last[idx];
            end else begin
                din_valid = 1'b0;
            end
            dout_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
            if (prev_stall && (dout_valid !== 1'b1 || txt_out_data !== pd ||
                               dout_keep !== pk || dout_last !== pl)) hold_err++;
            exp_rdy = !(occ == 2 && !dout_ready);
            if (din_ready !== exp_rdy) ready_err++;
            acc  = din_valid && din_ready;
            xfer = dout_valid && dout_ready;
            if (xfer) begin
                g_data.push_back(txt_out_data); g_keep.push_back(dout_keep); g_last.push_back(dout_last);
            end
            prev_stall = dout_valid && !dout_ready;
            pd = txt_out_data; pk = dout_keep; pl = dout_last;
            if (acc) idx++;
            occ = occ + int'(acc) - int'(xfer);
            @(posedge clk); #1;
            run_cycles = cyc + 1;
            if (idx == q_data.size() && g_data.size() == q_data.size()) begin
                run_timeout = 0;
                break;
            end
        end
        din_valid = 1'b0;
        dout_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_load = 1'b0; simmetric_key = '0; din_valid = 1'b0;
        txt_in_data = '0; din_keep = 4'h0; din_last = 1'b0; dout_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL reset_din_ready got=%b exp=0", din_ready); end
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL reset_dout_valid got=%b exp=0", dout_valid); end
        checks++; if (txt_out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", txt_out_data); end
        checks++; if (dout_keep !== 4'h0) begin failures++; $display("FAIL reset_keep got=%h exp=0", dout_keep); end
        checks++; if (dout_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", dout_last); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%b exp=1", din_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        load_key(32'h12121212);
        din_valid = 1'b1; txt_in_data = 32'h41; din_keep = 4'h1; din_last = 1'b0; dout_ready = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL dir_accept0 got=%b exp=1", din_ready); end
        @(posedge clk); #1;
        txt_in_data = 32'h42; din_last = 1'b1;
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL dir_latency got=%b exp=0", dout_valid); end
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(negedge clk);
        checks++; if (dout_valid !== 1'b1 || txt_out_data !== 32'h00000088 || dout_keep !== 4'h1 || dout_last !== 1'b0) begin
            failures++; $display("FAIL dir_beat0 got=%b/%h/%h/%b exp=1/00000088/1/0", dout_valid, txt_out_data, dout_keep, dout_last); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dout_valid !== 1'b1 || txt_out_data !== 32'h0000003F || dout_last !== 1'b1) begin
            failures++; $display("FAIL dir_beat1 got=%b/%h/%b exp=1/0000003f/1", dout_valid, txt_out_data, dout_last); end
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dout_valid !== 1'b0) begin failures++; $display("FAIL dir_drain got=%b exp=0", dout_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_partial_last();
        logic [31:0] ed [4];
        logic [3:0]  ek [4];
        logic        el [4];
        ed = '{32'hFEFEFEFE, 32'h30303030, 32'h0000F2F2, 32'hFEFEFEFE};
        ek = '{4'hF, 4'hF, 4'h3, 4'hF};
        el = '{1'b0, 1'b0, 1'b1, 1'b0};
        load_key(32'h0F0E0D0C);
        clear_queues();
        for (int i = 0; i < 4; i++) begin
            q_data.push_back(32'h0); q_keep.push_back(ek[i]); q_last.push_back(el[i]);
        end
        send_beats(1'b0, 50);
        checks++; if (run_timeout || g_data.size() != 4) begin failures++; $display("FAIL partial_count got=%0d exp=4", g_data.size()); end
        for (int i = 0; i < 4 && i < g_data.size(); i++) begin
            checks++;
            if (g_data[i] !== ed[i] || g_keep[i] !== ek[i] || g_last[i] !== el[i]) begin
                failures++;
                $display("FAIL partial_beat%0d got=%h/%h/%b exp=%h/%h/%b", i, g_data[i], g_keep[i], g_last[i], ed[i], ek[i], el[i]);
            end
        end
    endtask

    task automatic test_wrap();
        load_key(32'h0F0E0D0C);
        clear_queues();
        for (int i = 0; i < 65; i++) begin
            q_data.push_back(i < 63 ? $urandom() : 32'h0); q_keep.push_back(4'hF); q_last.push_back(1'b0);
        end
        build_expected();
        send_beats(1'b0, 200);
        checks++; if (run_timeout || g_data.size() != 65) begin failures++; $display("FAIL wrap_count got=%0d exp=65", g_data.size()); end
        checks++; if (run_cycles != 67) begin failures++; $display("FAIL wrap_throughput cycles got=%0d exp=67", run_cycles); end
        for (int i = 0; i < 65 && i < g_data.size(); i++) begin
            checks++;
            if (g_data[i] !== e_data[i]) begin failures++; $display("FAIL wrap_beat%0d got=%h exp=%h", i, g_data[i], e_data[i]); end
        end
        if (g_data.size() == 65) begin
            checks++; if (g_data[63] !== 32'h8C8C8C8C) begin failures++; $display("FAIL wrap_n252 got=%h exp=8c8c8c8c", g_data[63]); end
            checks++; if (g_data[64] !== 32'hFEFEFEFE) begin failures++; $display("FAIL wrap_n0 got=%h exp=fefefefe", g_data[64]); end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] kc [4];
        kc = '{4'h1, 4'h3, 4'h7, 4'hF};
        load_key(32'hA5C31F77);
        clear_queues();
        for (int i = 0; i < 60; i++) begin
            q_data.push_back($urandom()); q_keep.push_back(kc[$urandom_range(0, 3)]);
            q_last.push_back($urandom_range(0, 7) == 0);
        end
        build_expected();
        send_beats(1'b1, 2000);
        checks++; if (run_timeout || g_data.size() != 60) begin failures++; $display("FAIL bp_count got=%0d exp=60", g_data.size()); end
        checks++; if (hold_err != 0) begin failures++; $display("FAIL bp_hold violations got=%0d exp=0", hold_err); end
        checks++; if (ready_err != 0) begin failures++; $display("FAIL bp_ready deviations got=%0d exp=0", ready_err); end
        for (int i = 0; i < 60 && i < g_data.size(); i++) begin
            checks++;
            if (g_data[i] !== e_data[i] || g_keep[i] !== q_keep[i] || g_last[i] !== q_last[i]) begin
                failures++;
                $display("FAIL bp_beat%0d got=%h/%h/%b exp=%h/%h/%b", i, g_data[i], g_keep[i], g_last[i], e_data[i], q_keep[i], q_last[i]);
            end
        end
    endtask

    task automatic test_roundtrip();
        logic [31:0] plain[$];
        load_key(32'h0F0E0D0C);
        clear_queues();
        for (int i = 0; i < 256; i++) begin
            q_data.push_back($urandom()); q_keep.push_back(4'hF); q_last.push_back(i == 255);
        end
        plain = q_data;
        send_beats(1'b0, 600);
        checks++; if (run_timeout || g_data.size() != 256) begin failures++; $display("FAIL rt_encrypt_count got=%0d exp=256", g_data.size()); end
        q_data = g_data;
        load_key(32'h0F0E0D0C);
        send_beats(1'b1, 3000);
        checks++; if (run_timeout || g_data.size() != 256) begin failures++; $display("FAIL rt_decrypt_count got=%0d exp=256", g_data.size()); end
        for (int i = 0; i < 256 && i < g_data.size(); i++) begin
            checks++;
            if (g_data[i] !== plain[i]) begin failures++; $display("FAIL rt_beat%0d got=%h exp=%h", i, g_data[i], plain[i]); end
        end
    endtask

    task automatic test_key_load_midstream();
        int acc;
        bit took;
        logic [31:0] ed [3];
        ed = '{32'hFEFEFEFE, 32'h30303030, 32'h7B777C63};
        load_key(32'h0F0E0D0C);
        g_data.delete();
        dout_ready = 1'b0; din_valid = 1'b1; txt_in_data = 32'h0; din_keep = 4'hF; din_last = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 10 && acc < 2; cyc++) begin
            @(negedge clk);
            if (din_valid && din_ready) acc++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        checks++; if (acc != 2 || din_ready !== 1'b0) begin failures++; $display("FAIL kl_fill accepted=%0d ready=%b exp=2/0", acc, din_ready); end
        @(posedge clk); #1;
        key_load = 1'b1; simmetric_key = 32'h0; m_key = 32'h0; dout_ready = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b0) begin failures++; $display("FAIL kl_ready got=%b exp=0", din_ready); end
        if (dout_valid && dout_ready) g_data.push_back(txt_out_data);
        @(posedge clk); #1;
        key_load = 1'b0;
        for (int cyc = 0; cyc < 10 && g_data.size() < 3; cyc++) begin
            @(negedge clk);
            if (dout_valid && dout_ready) g_data.push_back(txt_out_data);
            took = din_valid && din_ready;
            @(posedge clk); #1;
            if (took) din_valid = 1'b0;
        end
        checks++; if (g_data.size() != 3) begin failures++; $display("FAIL kl_count got=%0d exp=3", g_data.size()); end
        for (int i = 0; i < 3 && i < g_data.size(); i++) begin
            checks++;
            if (g_data[i] !== ed[i]) begin failures++; $display("FAIL kl_beat%0d got=%h exp=%h", i, g_data[i], ed[i]); end
        end
        din_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        load_key(32'h0F0E0D0C);
        din_valid = 1'b1; txt_in_data = 32'h0; din_keep = 4'hF; din_last = 1'b0; dout_ready = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        checks++; if (dout_valid !== 1'b1) begin failures++; $display("FAIL ar_pre_valid got=%b exp=1", dout_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dout_valid !== 1'b0 || din_ready !== 1'b0 || txt_out_data !== 32'h0) begin
            failures++; $display("FAIL ar_immediate got=%b/%b/%h exp=0/0/00000000", dout_valid, din_ready, txt_out_data); end
        din_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        din_valid = 1'b1;
        @(negedge clk);
        checks++; if (din_ready !== 1'b1) begin failures++; $display("FAIL ar_ready got=%b exp=1", din_ready); end
        @(posedge clk); #1;
        din_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (dout_valid !== 1'b1 || txt_out_data !== 32'h7B777C63) begin
            failures++; $display("FAIL ar_zero_key got=%b/%h exp=1/7b777c63", dout_valid, txt_out_data); end
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        m_key = '0;
        build_sbox();
        test_reset();
        test_directed();
        test_partial_last();
        test_wrap();
        test_backpressure();
        test_roundtrip();
        test_key_load_midstream();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/aes_sbox_stream_cipher_mlane.md
# aes_sbox_stream_cipher_mlane

Multi-lane, parametrised successor of the single-byte AES S-box stream cipher. Each beat carries LANES bytes, each XORed with a keystream byte derived from the AES forward S-box, a multi-byte key and a per-message byte counter. Encryption and decryption are the same operation. Adds valid/ready backpressure on both sides, partial last beats and message-boundary counter reset. Sits between the file/byte source and sink in the cipher datapath.

## Interface
- LANES, 4: bytes per beat; 1..16.
- KEY_BYTES, 1: key length in bytes; power of two, 1..16.
- clk  input  1: clock; all logic on rising edge.
- rst_n  input  1: reset, asynchronous, active-low.
- key_load  input  1: latch simmetric_key and clear the byte counter.
- simmetric_key  input  8*KEY_BYTES: key; byte k at bits [8k+7:8k].
- din_valid  input  1: input beat valid.
- din_ready  output  1: input beat accepted when din_valid && din_ready.
- txt_in_data  input  8*LANES: input bytes; lane i at [8i+7:8i].
- din_keep  input  LANES: lane enables; contiguous from lane 0, at least one bit set.
- din_last  input  1: final beat of a message.
- dout_valid  output  1: output beat valid.
- dout_ready  input  1: sink accepts the output beat.
- txt_out_data  output  8*LANES: result bytes.
- dout_keep  output  LANES: copy of din_keep; zero lanes drive 8'h00.
- dout_last  output  1: copy of din_last.

## Operation
- Key register K holds KEY_BYTES bytes. Byte counter C is 8 bits.
- For an accepted beat, lane i uses byte index n = C + i (mod 256):
  - ks_i = SBOX[K[n mod KEY_BYTES] ^ n];
  - out_i = in_i ^ ks_i.
- SBOX is the standard AES forward S-box, with one combinational ROM per lane.
- After each accepted beat, C advances by popcount(din_keep), wrapping mod 256.
- If din_last is set on the accepted beat, C is cleared to 0 instead.
- key_load:
  - Latches K and clears C.
  - Forces din_ready=0 for that cycle, so no beat is accepted.
  - Beats already in the pipeline complete with their old keystream.
- The pipeline has two stages:
  - S1 registers the input bytes, keep, last and ks (computed from C/K at acceptance).
  - S2 registers the XOR result and drives the outputs.
- Both stages hold their contents while the downstream stage stalls. No beat is dropped or duplicated.
- din_ready = !key_load && (!s1_valid || !s2_valid || dout_ready).

## Timing
- Reset values:
  - din_ready=0 while rst_n=0, then follows the ready equation.
  - dout_valid=0, txt_out_data=0, dout_keep=0, dout_last=0.
  - K=0, C=0, both stage valids 0.
- Latency: beat accepted at edge E0; dout_valid is high after edge E0+2.
- Throughput: one beat per cycle while dout_ready=1.
- Output stall (dout_ready=0): S2 holds, then S1 fills. din_ready drops once both stages are full and returns in the same cycle dout_ready rises.
- The source must hold din_* stable until acceptance. The cipher must hold dout_* stable while dout_valid && !dout_ready.
- key_load and din_valid in the same cycle: key_load wins; the beat is accepted no earlier than the next cycle, using the new key and C=0.
- Counter wrap: at C=254 with LANES=4, the lanes use n=254, 255, 0, 1, and C becomes 2.
- Asynchronous reset mid-operation clears all in-flight beats, K and C immediately.

## Configuration
- AES_SBOX_SC_BYTE_COUNT_EN:
  - Defined: adds output port byte_count (32 bits). It is a saturating count of output bytes transferred (popcount of dout_keep when dout_valid && dout_ready). It resets to 0 on rst_n and on key_load.
  - Undefined: the port and its logic are absent.

## Test plan
- LANES=1, KEY_BYTES=1, key 8'h12, input bytes 8'h41, 8'h42 -> output 8'h88 (8'h41^SBOX[12]=C9), then 8'h3F (8'h42^SBOX[13]=7D); each appears 2 cycles after acceptance.
- Round trip: LANES=4, KEY_BYTES=4, key 32'h0F0E0D0C, a 1 KiB random message, output fed back after a key_load -> plaintext reproduced bit-exact.
- Backpressure: random dout_ready (50%) with din_valid held at 1 -> no loss or duplication, stable held outputs, and din_ready low only when both stages are full.
- Partial last beat: LANES=4, beats with keep 4'hF, 4'hF, 4'h3 and last set -> C goes 4, 8, then 0; dout_keep 4'h3, upper lanes 8'h00; the next message's lane 0 uses n=0.
- Wrap: after 63 full 4-lane beats (C=252), the next beat uses n=252..255 and the following beat uses n=0..3 -> keystream matches the model.
- key_load asserted with din_valid=1 and the pipeline full -> din_ready=0 that cycle; in-flight beats use the old key; the next beat uses the new key with n=0. Asynchronous rst_n pulse mid-stream -> dout_valid=0 immediately.
